kbd_seg_light: RTL and testbench

- Board-level I/O demo block. Combines a free-running 16-bit one-hot LED chaser, a PS/2 keyboard frame receiver with scan-code tracking, and an 8-digit seven-segment hex display of keyboard state.
- Sits directly under the board top. It drives ledr and seg0..seg7, and is fed by the raw ps2_clk/ps2_data pins.

---
 rtl/kbd_seg_light.sv | 162 ++++++++++++++++
 tb/tb_kbd_seg_light.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/kbd_seg_light.sv
// ============================================================================
// Module   : kbd_seg_light
// Brief    : LED chaser, PS/2 scan-code receiver and 8-digit hex display.
//            Optional macro PS2_PARITY_CHECK_EN enables odd-parity checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kbd_seg_light #(
    parameter int LED_DIV = 5000000,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] led,
    output logic [7:0]  seg0,
    output logic [7:0]  seg1,
    output logic [7:0]  seg2,
    output logic [7:0]  seg3,
    output logic [7:0]  seg4,
    output logic [7:0]  seg5,
    output logic [7:0]  seg6,
    output logic [7:0]  seg7
);

    localparam int                LED_CW   = $clog2(LED_DIV);
    localparam logic [LED_CW-1:0] LED_LAST = LED_CW'(LED_DIV - 1);
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    logic [LED_CW-1:0] led_cnt;
    logic [2:0]        ps2_sync;
    logic [3:0]        bit_cnt;
    logic [9:0]        shreg;
    logic              held;
    logic              brk;
    logic              has_last;
    logic [7:0]        cur_code;
    logic [7:0]        last_code;
    logic [CNT_W-1:0]  press_cnt;
    logic [7:0]        cnt8;

    logic              fall;
    logic              frame_end;
    logic              parity_odd;
    logic              parity_ok;
    logic              frame_ok;
    logic [7:0]        byte_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_cnt <= '0;
            led     <= 16'h0001;
        end else if (led_cnt == LED_LAST) begin
            led_cnt <= '0;
            led     <= {led[14:0], led[15]};
        end else begin
            led_cnt <= led_cnt + 1'b1;
        end
    end

    // Sync flops reset low so a line already low at release is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ps2_sync <= 3'b000;
        else     ps2_sync <= {ps2_sync[1:0], ps2_clk};
    end

    // After ten shifts shreg holds start(bit0), d0..d7, parity(bit9); stop is live data.
    assign fall       = ps2_sync[2] & ~ps2_sync[1];
    assign frame_end  = fall && (bit_cnt == 4'd10);
    assign byte_in    = shreg[8:1];
    assign parity_odd = ^shreg[9:1];
    assign parity_ok  = PARITY_EN ? parity_odd : 1'b1;
    assign frame_ok   = frame_end & ~shreg[0] & ps2_data & parity_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= 4'd0;
            shreg   <= 10'd0;
        end else if (fall) begin
            shreg   <= {ps2_data, shreg[9:1]};
            bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held      <= 1'b0;
            brk       <= 1'b0;
            has_last  <= 1'b0;
            cur_code  <= 8'h00;
            last_code <= 8'h00;
            press_cnt <= '0;
        end else if (frame_ok) begin
            if (byte_in == 8'hF0) begin
                brk <= 1'b1;
            end else if (byte_in == 8'hE0) begin
                brk <= brk;
            end else if (brk) begin
                held <= 1'b0;
                brk  <= 1'b0;
            end else if (!(held && (byte_in == cur_code))) begin
                cur_code  <= byte_in;
                last_code <= byte_in;
                held      <= 1'b1;
                has_last  <= 1'b1;
                press_cnt <= press_cnt + 1'b1;
            end
        end
    end

    generate
        if (CNT_W >= 8) begin : g_cnt_wide
            assign cnt8 = press_cnt[7:0];
        end else begin : g_cnt_narrow
            assign cnt8 = {{(8 - CNT_W){1'b0}}, press_cnt};
        end
    endgenerate

    function automatic logic [7:0] hex_glyph(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0: g = 8'h03;  4'h1: g = 8'h9F;  4'h2: g = 8'h25;  4'h3: g = 8'h0D;
            4'h4: g = 8'h99;  4'h5: g = 8'h49;  4'h6: g = 8'h41;  4'h7: g = 8'h1F;
            4'h8: g = 8'h01;  4'h9: g = 8'h09;  4'hA: g = 8'h11;  4'hB: g = 8'hC1;
            4'hC: g = 8'h63;  4'hD: g = 8'h85;  4'hE: g = 8'h61;  default: g = 8'h71;
        endcase
        return g;
    endfunction

    // Display is blanked while reset is held; counter digits appear once released.
    always_comb begin
        seg0 = 8'hFF;
        seg1 = 8'hFF;
        seg2 = 8'hFF;
        seg3 = 8'hFF;
        seg4 = 8'hFF;
        seg5 = 8'hFF;
        seg6 = 8'hFF;
        seg7 = 8'hFF;
        if (!rst) begin
            if (held) begin
                seg0 = hex_glyph(cur_code[3:0]);
                seg1 = hex_glyph(cur_code[7:4]);
            end
            if (has_last) begin
                seg2 = hex_glyph(last_code[3:0]);
                seg3 = hex_glyph(last_code[7:4]);
            end
            seg4 = hex_glyph(cnt8[3:0]);
            seg5 = hex_glyph(cnt8[7:4]);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_kbd_seg_light.sv
// ============================================================================
// Module   : tb_kbd_seg_light
// Brief    : Scoreboard bench for kbd_seg_light (LED_DIV=4, directed frames).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_kbd_seg_light;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] led;
    logic [7:0]  seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
    logic [63:0] segs;

    typedef struct {
        string       name;
        bit          is_led;
        logic [63:0] exp;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [63:0] act;
    int          checks = 0;
    int          errors = 0;

    kbd_seg_light #(.LED_DIV(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .led(led),
        .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
        .seg4(seg4), .seg5(seg5), .seg6(seg6), .seg7(seg7)
    );

    always #5 clk = ~clk;
    assign segs = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            act = cur.is_led ? {48'h0, led} : segs;
            checks++;
            if (act !== cur.exp) begin
                errors++;
                $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
            end
        end
    end

    task automatic expect_val(input string n, input bit is_led, input logic [63:0] v);
        exp_t e;
        e.name   = n;
        e.is_led = is_led;
        e.exp    = v;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] code, input bit par_flip,
                              input bit bad_stop, input int nbits);
        logic [10:0] bits;
        bits[0]   = 1'b0;
        bits[8:1] = code;
        bits[9]   = ~(^code) ^ par_flip;
        bits[10]  = ~bad_stop;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            repeat (6) @(posedge clk);
            ps2_clk = 1'b0;
            repeat (12) @(posedge clk);
            ps2_clk = 1'b1;
            repeat (6) @(posedge clk);
        end
        ps2_data = 1'b1;
        repeat (20) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(posedge clk);
        expect_val("rst_led", 1'b1, 64'h0001);
        expect_val("rst_seg", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk);
        #1 rst = 1'b0;

        repeat (3) @(posedge clk);
        expect_val("led_c3", 1'b1, 64'h0001);
        @(posedge clk);
        expect_val("led_c4", 1'b1, 64'h0002);
        expect_val("idle_seg", 1'b0, 64'hFFFF_0303_FFFF_FFFF);
        repeat (4) @(posedge clk);
        expect_val("led_c8", 1'b1, 64'h0004);
        repeat (4) @(posedge clk);
        expect_val("led_c12", 1'b1, 64'h0008);
        repeat (243) @(posedge clk);
        expect_val("led_c255", 1'b1, 64'h8000);
        @(posedge clk);
        expect_val("led_wrap", 1'b1, 64'h0001);

        send_frame(8'h1C, 1'b0, 1'b0, 11);
        expect_val("make_1c", 1'b0, 64'hFFFF_039F_9F63_9F63);
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        expect_val("typematic", 1'b0, 64'hFFFF_039F_9F63_9F63);
        send_frame(8'hF0, 1'b0, 1'b0, 11);
        expect_val("brk_f0", 1'b0, 64'hFFFF_039F_9F63_9F63);
        send_frame(8'h1C, 1'b0, 1'b0, 11);
        expect_val("break_1c", 1'b0, 64'hFFFF_039F_9F63_FFFF);
        send_frame(8'hE0, 1'b0, 1'b0, 11);
        expect_val("ext_e0", 1'b0, 64'hFFFF_039F_9F63_FFFF);
        send_frame(8'h75, 1'b0, 1'b0, 11);
        expect_val("make_75", 1'b0, 64'hFFFF_0325_1F49_1F49);
        send_frame(8'hF0, 1'b0, 1'b0, 11);
        send_frame(8'h75, 1'b0, 1'b0, 11);
        expect_val("break_75", 1'b0, 64'hFFFF_0325_1F49_FFFF);
        send_frame(8'h22, 1'b0, 1'b1, 11);
        expect_val("bad_stop", 1'b0, 64'hFFFF_0325_1F49_FFFF);
        send_frame(8'h1C, 1'b1, 1'b0, 11);
`ifdef PS2_PARITY_CHECK_EN
        expect_val("bad_parity", 1'b0, 64'hFFFF_0325_1F49_FFFF);
`else
        expect_val("bad_parity", 1'b0, 64'hFFFF_030D_9F63_9F63);
`endif

        send_frame(8'h32, 1'b0, 1'b0, 5);
        #3 rst = 1'b1;
        @(posedge clk);
        expect_val("mid_rst_led", 1'b1, 64'h0001);
        expect_val("mid_rst_seg", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        expect_val("restart_c3", 1'b1, 64'h0001);
        @(posedge clk);
        expect_val("restart_c4", 1'b1, 64'h0002);
        expect_val("restart_seg", 1'b0, 64'hFFFF_0303_FFFF_FFFF);
        send_frame(8'h32, 1'b0, 1'b0, 11);
        expect_val("make_32", 1'b0, 64'hFFFF_039F_0D25_0D25);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
